systolic_row_mac: RTL and testbench

//  Parametrised 1xN systolic MAC row: N PEs share one B stream that ripples one PE per

---
 rtl/systolic_row_mac.sv | 147 ++++++++++++++
 tb/tb_systolic_row_mac.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_row_mac.sv
// rtl/systolic_row_mac.sv - 1xN systolic MAC row with saturating accumulators and serial drain
// B ripples one PE per cycle; A lanes are live. Flush drains the pipe, then streams N results out.
module systolic_row_mac #(
    parameter int N_PE = 4,
    parameter int DW   = 16,
    parameter int AW   = 40,
    parameter int SAT  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DW-1:0]              b_in,
    input  logic [N_PE*DW-1:0]         a_vec,
    input  logic                       flush,
    output logic                       c_valid,
    input  logic                       c_ready,
    output logic [AW-1:0]              c_data,
    output logic [$clog2(N_PE)-1:0]    c_idx,
    output logic                       c_ovf,
    output logic                       busy
);

    localparam int IW = $clog2(N_PE);
    localparam logic [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

    typedef enum logic [1:0] {S_ACCUM, S_FLUSH, S_DRAIN} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_cnt;
    logic [IW-1:0]   r_idx;
    logic            w_accept;
    logic            w_clear;
    logic            w_last_idx;

    logic            w_v [0:N_PE-1];
    logic [DW-1:0]   w_b [0:N_PE-1];
    logic            r_v [1:N_PE-1];
    logic [DW-1:0]   r_b [1:N_PE-1];

    logic [AW-1:0]   w_acc_arr [0:N_PE-1];
    logic [N_PE-1:0] w_ovf_vec;

    assign in_ready   = (r_state == S_ACCUM);
    assign busy       = (r_state == S_FLUSH) || (r_state == S_DRAIN);
    assign w_accept   = in_valid && in_ready;
    assign w_last_idx = (r_idx == IW'(N_PE - 1));
    assign w_clear    = (r_state == S_DRAIN) && c_ready && w_last_idx;

    assign c_valid = (r_state == S_DRAIN);
    assign c_data  = c_valid ? w_acc_arr[r_idx] : '0;
    assign c_ovf   = c_valid && w_ovf_vec[r_idx];
    assign c_idx   = r_idx;

    // Stage 0 is the accepted beat itself; idle cycles push zeros down the pipe.
    assign w_v[0] = w_accept;
    assign w_b[0] = w_accept ? b_in : '0;

    genvar gi;
    generate
        for (gi = 1; gi < N_PE; gi++) begin : g_pipe
            assign w_v[gi] = r_v[gi];
            assign w_b[gi] = r_b[gi];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_v[gi] <= 1'b0;
                    r_b[gi] <= '0;
                end else begin
                    r_v[gi] <= w_v[gi-1];
                    r_b[gi] <= w_b[gi-1];
                end
            end
        end

        for (gi = 0; gi < N_PE; gi++) begin : g_pe
            logic signed [DW-1:0]   w_a;
            logic signed [DW-1:0]   w_bs;
            logic signed [2*DW-1:0] w_prod;
            logic [AW-1:0]          w_ext;
            logic [AW-1:0]          w_sum;
            logic [AW-1:0]          w_nxt;
            logic                   w_add_ovf;
            logic [AW-1:0]          r_acc;
            logic                   r_ovf;

            assign w_a    = a_vec[gi*DW +: DW];
            assign w_bs   = w_b[gi];
            assign w_prod = w_a * w_bs;
            assign w_ext  = AW'(w_prod);
            assign w_sum  = r_acc + w_ext;
            // Signed overflow: operands agree in sign but the sum does not.
            assign w_add_ovf = (r_acc[AW-1] == w_ext[AW-1]) && (w_sum[AW-1] != r_acc[AW-1]);
            assign w_nxt = (w_add_ovf && (SAT != 0)) ? (r_acc[AW-1] ? ACC_MIN : ACC_MAX) : w_sum;

            assign w_acc_arr[gi] = r_acc;
            assign w_ovf_vec[gi] = r_ovf;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_acc <= '0;
                    r_ovf <= 1'b0;
                end else if (w_clear) begin
                    r_acc <= '0;
                    r_ovf <= 1'b0;
                end else if (w_v[gi]) begin
                    r_acc <= w_nxt;
                    if (w_add_ovf) begin
                        r_ovf <= 1'b1;
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_ACCUM: if (flush) w_state_nxt = S_FLUSH;
            // r_cnt counts FLUSH cycles still to run, including the current one.
            S_FLUSH: if (r_cnt == IW'(1)) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_clear) w_state_nxt = S_ACCUM;
            default: w_state_nxt = S_ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_ACCUM;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_ACCUM && flush) begin
                r_cnt <= IW'(N_PE - 1);
            end else if (r_state == S_FLUSH) begin
                r_cnt <= r_cnt - IW'(1);
            end
            if (r_state == S_DRAIN && c_ready) begin
                r_idx <= w_last_idx ? '0 : r_idx + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_systolic_row_mac.sv
// tb/tb_systolic_row_mac.sv - scoreboard bench for systolic_row_mac
module tb_systolic_row_mac;

    typedef struct packed { logic [39:0] d; logic [1:0] i; logic o; } exp_t;
    typedef struct packed { logic [31:0] d; logic [1:0] i; logic o; } exp32_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, flush, c_valid, c_ready, c_ovf, busy;
    logic [15:0] b_in;
    logic [63:0] a_vec;
    logic [39:0] c_data;
    logic [1:0]  c_idx;

    logic        x_in_valid, x_flush, x_c_ready;
    logic [15:0] x_b_in;
    logic [63:0] x_a_vec;
    logic        s_in_ready, s_c_valid, s_c_ovf, s_busy;
    logic [31:0] s_c_data;
    logic [1:0]  s_c_idx;
    logic        w_in_ready, w_c_valid, w_c_ovf, w_busy;
    logic [31:0] w_c_data;
    logic [1:0]  w_c_idx;

    exp_t   q[$];
    exp32_t qs[$];
    exp32_t qw[$];
    int     n_cmp = 0;
    int     n_err = 0;
    bit     last_hs = 0;
    bit     bp_en = 0;
    int     cyc = 0;
    logic [3:0] bp_pat = 4'b1001;

    always #5 clk = ~clk;

    systolic_row_mac #(.N_PE(4), .DW(16), .AW(40), .SAT(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .b_in(b_in),
        .a_vec(a_vec), .flush(flush), .c_valid(c_valid), .c_ready(c_ready),
        .c_data(c_data), .c_idx(c_idx), .c_ovf(c_ovf), .busy(busy));

    systolic_row_mac #(.N_PE(4), .DW(16), .AW(32), .SAT(1)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(x_in_valid), .in_ready(s_in_ready), .b_in(x_b_in),
        .a_vec(x_a_vec), .flush(x_flush), .c_valid(s_c_valid), .c_ready(x_c_ready),
        .c_data(s_c_data), .c_idx(s_c_idx), .c_ovf(s_c_ovf), .busy(s_busy));

    systolic_row_mac #(.N_PE(4), .DW(16), .AW(32), .SAT(0)) dut_wrap (
        .clk(clk), .rst(rst), .in_valid(x_in_valid), .in_ready(w_in_ready), .b_in(x_b_in),
        .a_vec(x_a_vec), .flush(x_flush), .c_valid(w_c_valid), .c_ready(x_c_ready),
        .c_data(w_c_data), .c_idx(w_c_idx), .c_ovf(w_c_ovf), .busy(w_busy));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [15:0] b, input logic f);
        in_valid = 1'b1;
        b_in     = b;
        flush    = f;
        step();
        in_valid = 1'b0;
        flush    = 1'b0;
        b_in     = '0;
    endtask

    task automatic flush_only();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic push4(input logic [39:0] d0, input logic [39:0] d1,
                         input logic [39:0] d2, input logic [39:0] d3);
        logic [39:0] d [4];
        exp_t e;
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        for (int k = 0; k < 4; k++) begin
            e.d = d[k];
            e.i = 2'(k);
            e.o = 1'b0;
            q.push_back(e);
        end
    endtask

    task automatic wait_drain(input bit noise);
        bit done = 0;
        if (noise) begin
            in_valid = 1'b1;
            b_in     = 16'd100;
        end
        for (int k = 0; k < 300; k++) begin
            if (q.size() == 0 && qs.size() == 0 && qw.size() == 0) begin
                done = 1;
                break;
            end
            step();
        end
        in_valid = 1'b0;
        b_in     = '0;
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size() + qs.size() + qw.size());
        end
    endtask

    always @(posedge clk) begin
        #1;
        cyc++;
        c_ready = bp_en ? bp_pat[cyc % 4] : 1'b1;
    end

    // Main scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (last_hs) begin
                chk("in_ready_after_drain", 64'(in_ready), 64'd1);
                chk("c_valid_after_drain", 64'(c_valid), 64'd0);
                last_hs = 0;
            end
            if (c_valid) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_beat: got idx %0d data %0h expected none", c_idx, c_data);
                end else begin
                    chk("c_data", 64'(c_data), 64'(q[0].d));
                    chk("c_idx", 64'(c_idx), 64'(q[0].i));
                    chk("c_ovf", 64'(c_ovf), 64'(q[0].o));
                    chk("in_ready_in_drain", 64'(in_ready), 64'd0);
                    if (c_ready) begin
                        if (c_idx == 2'd3) last_hs = 1;
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    // Saturating / wrapping pair monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (s_c_valid) begin
                if (qs.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL sat_unexpected: got %0h expected none", s_c_data);
                end else begin
                    chk("sat_data", 64'(s_c_data), 64'(qs[0].d));
                    chk("sat_idx", 64'(s_c_idx), 64'(qs[0].i));
                    chk("sat_ovf", 64'(s_c_ovf), 64'(qs[0].o));
                    void'(qs.pop_front());
                end
            end
            if (w_c_valid) begin
                if (qw.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL wrap_unexpected: got %0h expected none", w_c_data);
                end else begin
                    chk("wrap_data", 64'(w_c_data), 64'(qw[0].d));
                    chk("wrap_idx", 64'(w_c_idx), 64'(qw[0].i));
                    chk("wrap_ovf", 64'(w_c_ovf), 64'(qw[0].o));
                    void'(qw.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got time %0t expected finish", $time);
        $fatal(1, "timeout");
    end

    initial begin
        exp32_t e32;
        bit     seen;
        rst = 1'b1; in_valid = 0; flush = 0; b_in = 0; a_vec = 0; c_ready = 1'b1;
        x_in_valid = 0; x_flush = 0; x_b_in = 0; x_a_vec = 0; x_c_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_c_valid", 64'(c_valid), 64'd0);
        chk("rst_c_data", 64'(c_data), 64'd0);
        chk("rst_c_idx", 64'(c_idx), 64'd0);
        chk("rst_c_ovf", 64'(c_ovf), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // 1) held A=2, b=1,2,3 -> 12 per PE
        a_vec = {4{16'd2}};
        push4(40'd12, 40'd12, 40'd12, 40'd12);
        beat(16'd1, 0); beat(16'd2, 0); beat(16'd3, 0);
        flush_only();
        chk("busy_in_flush", 64'(busy), 64'd1);
        chk("in_ready_in_flush", 64'(in_ready), 64'd0);
        wait_drain(0);

        // 2) signed product -3*5
        a_vec = {16'd0, 16'd0, 16'd0, 16'hFFFD};
        push4(40'hFF_FFFF_FFF1, 40'd0, 40'd0, 40'd0);
        beat(16'd5, 0);
        flush_only();
        wait_drain(0);

        // 3) 3 x (2^30) into a 32-bit accumulator: clamp vs wrap
        x_a_vec = {48'd0, 16'h8000};
        for (int k = 0; k < 4; k++) begin
            e32.i = 2'(k);
            e32.o = (k == 0);
            e32.d = (k == 0) ? 32'h7FFF_FFFF : 32'd0;
            qs.push_back(e32);
            e32.d = (k == 0) ? 32'hC000_0000 : 32'd0;
            qw.push_back(e32);
        end
        x_in_valid = 1'b1;
        x_b_in     = 16'h8000;
        repeat (3) step();
        x_in_valid = 1'b0;
        x_b_in     = '0;
        x_flush    = 1'b1;
        step();
        x_flush    = 1'b0;
        wait_drain(0);

        // 4) backpressure on the result port, distinct per-lane results
        a_vec = {16'd4, 16'd3, 16'd2, 16'd1};
        bp_en = 1;
        push4(40'd4, 40'd8, 40'd12, 40'd16);
        beat(16'd4, 0);
        flush_only();
        wait_drain(0);
        bp_en = 0;

        // 5) beat with flush in the same cycle; beats offered during FLUSH/DRAIN are ignored
        a_vec = {4{16'd1}};
        push4(40'd10, 40'd10, 40'd10, 40'd10);
        beat(16'd3, 0);
        beat(16'd7, 1);
        wait_drain(1);

        // 6) reset in the middle of a drain
        a_vec = {4{16'd3}};
        push4(40'd6, 40'd6, 40'd6, 40'd6);
        beat(16'd2, 0);
        flush_only();
        seen = 0;
        for (int k = 0; k < 50; k++) begin
            step();
            if (c_valid && c_idx == 2'd1) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            n_cmp++; n_err++;
            $display("FAIL reach_idx1: got idx %0d expected 1", c_idx);
        end
        rst = 1'b1;
        q.delete();
        #1;
        chk("midrst_c_valid", 64'(c_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_c_idx", 64'(c_idx), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        a_vec = {4{16'd1}};
        push4(40'd1, 40'd1, 40'd1, 40'd1);
        beat(16'd1, 0);
        flush_only();
        wait_drain(0);

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
